fp_cmp_unit: RTL

Multi-cycle IEEE-754 compare, min/max and classify unit for single (32-bit) and half (16-bit) precision. It is the responder side of the ALU request protocol: it accepts operands on `start`, runs a fixed-latency sequence and returns `result`, `valid_out` and `flags`. It uses the same port set and handshake as the arithmetic ALU, so the existing operation-driving benches can exercise it without changes.

---
 rtl/fp_cmp_unit.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_cmp_unit.sv
// fp_cmp_unit: multi-cycle IEEE-754 compare / min / max / classify unit for
// single and half precision, speaking the ALU start/valid_out handshake.
// Sequence: IDLE -> DECODE -> EXEC -> DONE, result registered on leaving EXEC.
// Optional feature macro: FP_CMP_HP_EN (half-precision support). Without it
// mode_fp is ignored and every operation is single precision.
module fp_cmp_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [2:0]  op_code,
    input  logic        mode_fp,
    input  logic        round_mode,
    input  logic        start,
    output logic [31:0] result,
    output logic        valid_out,
    output logic [4:0]  flags
);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, DONE} state_t;

    localparam logic [2:0] OP_EQ    = 3'b000;
    localparam logic [2:0] OP_LT    = 3'b001;
    localparam logic [2:0] OP_LE    = 3'b010;
    localparam logic [2:0] OP_MIN   = 3'b011;
    localparam logic [2:0] OP_MAX   = 3'b100;
    localparam logic [2:0] OP_CLASS = 3'b101;

    localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
    localparam logic [31:0] QNAN_HP = 32'h0000_7E00;

    // Unpacked operand: bit-exact return value, sign, magnitude and one-hot class.
    typedef struct packed {
        logic        sign;
        logic [30:0] mag;
        logic [9:0]  cls;
        logic [31:0] val;
    } unpk_t;

    // One-hot class in the CLASS result bit order.
    function automatic logic [9:0] classify(input logic sign, input logic exp_max,
                                            input logic exp_zero, input logic man_zero,
                                            input logic man_msb);
        logic [9:0] c;
        c = '0;
        if (exp_max) begin
            if (man_zero)     c[sign ? 0 : 7] = 1'b1;
            else if (man_msb) c[9] = 1'b1;
            else              c[8] = 1'b1;
        end else if (exp_zero) begin
            if (man_zero)     c[sign ? 3 : 4] = 1'b1;
            else              c[sign ? 2 : 5] = 1'b1;
        end else begin
            c[sign ? 1 : 6] = 1'b1;
        end
        return c;
    endfunction

    function automatic unpk_t unpack_sp(input logic [31:0] x);
        unpk_t u;
        u.val  = x;
        u.sign = x[31];
        u.mag  = x[30:0];
        u.cls  = classify(x[31], &x[30:23], ~|x[30:23], ~|x[22:0], x[22]);
        return u;
    endfunction

`ifdef FP_CMP_HP_EN
    function automatic unpk_t unpack_hp(input logic [15:0] x);
        unpk_t u;
        u.val  = {16'h0000, x};
        u.sign = x[15];
        u.mag  = {16'h0000, x[14:0]};
        u.cls  = classify(x[15], &x[14:10], ~|x[14:10], ~|x[9:0], x[9]);
        return u;
    endfunction
`endif

    // Signed ordering key: -0 and +0 both map to 0, so IEEE equality of zeros falls out.
    function automatic logic signed [31:0] order_key(input logic sign, input logic [30:0] mag);
        logic signed [31:0] k;
        k = signed'({1'b0, mag});
        return sign ? -k : k;
    endfunction

    state_t state, state_nxt;

    logic sp_in;
`ifdef FP_CMP_HP_EN
    assign sp_in = mode_fp;
`else
    assign sp_in = 1'b1;
`endif

    logic [31:0] a_p0, b_p0;
    logic [2:0]  opc_p0;
    logic        sp_p0;

    unpk_t ua, ub;

    logic [31:0]        val_a_p1, val_b_p1;
    logic signed [31:0] key_a_p1, key_b_p1;
    logic               sign_a_p1, sign_b_p1;
    logic [9:0]         cls_a_p1;
    logic               qnan_b_p1, snan_b_p1;

    logic [31:0] res_d;
    logic        inv_d;

    logic unused_ok;
    assign unused_ok = ^{round_mode, mode_fp, ub.cls[7:0]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DECODE;
            DECODE:  state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p0: operand capture on request acceptance
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_p0   <= op_a;
            b_p0   <= op_b;
            opc_p0 <= op_code;
            sp_p0  <= sp_in;
        end
    end

    // Unpack both latched operands in the selected format
    always_comb begin
`ifdef FP_CMP_HP_EN
        ua = sp_p0 ? unpack_sp(a_p0) : unpack_hp(a_p0[15:0]);
        ub = sp_p0 ? unpack_sp(b_p0) : unpack_hp(b_p0[15:0]);
`else
        ua = unpack_sp(a_p0);
        ub = unpack_sp(b_p0);
`endif
    end

    // ---- stage p1: decoded operands registered in DECODE
    always_ff @(posedge clk) begin
        if (state == DECODE) begin
            val_a_p1  <= ua.val;
            val_b_p1  <= ub.val;
            key_a_p1  <= order_key(ua.sign, ua.mag);
            key_b_p1  <= order_key(ub.sign, ub.mag);
            sign_a_p1 <= ua.sign;
            sign_b_p1 <= ub.sign;
            cls_a_p1  <= ua.cls;
            qnan_b_p1 <= ub.cls[9];
            snan_b_p1 <= ub.cls[8];
        end
    end

    // Compute result and invalid flag from decoded operands
    always_comb begin
        logic nan_a, nan_b, any_nan, any_snan;
        logic num_lt, num_eq, a_below_b, b_below_a;
        res_d     = 32'h0;
        inv_d     = 1'b0;
        nan_a     = cls_a_p1[9] | cls_a_p1[8];
        nan_b     = qnan_b_p1 | snan_b_p1;
        any_nan   = nan_a | nan_b;
        any_snan  = cls_a_p1[8] | snan_b_p1;
        num_lt    = key_a_p1 < key_b_p1;
        num_eq    = key_a_p1 == key_b_p1;
        // Total order for min/max: -0 sits below +0
        a_below_b = num_lt | (num_eq & sign_a_p1 & ~sign_b_p1);
        b_below_a = (key_b_p1 < key_a_p1) | (num_eq & sign_b_p1 & ~sign_a_p1);
        case (opc_p0)
            OP_EQ: begin
                res_d = {31'h0, ~any_nan & num_eq};
                inv_d = any_snan;
            end
            OP_LT: begin
                res_d = {31'h0, ~any_nan & num_lt};
                inv_d = any_nan;
            end
            OP_LE: begin
                res_d = {31'h0, ~any_nan & (num_lt | num_eq)};
                inv_d = any_nan;
            end
            OP_MIN, OP_MAX: begin
                if (nan_a && nan_b)  res_d = sp_p0 ? QNAN_SP : QNAN_HP;
                else if (nan_a)      res_d = val_b_p1;
                else if (nan_b)      res_d = val_a_p1;
                else if (opc_p0 == OP_MIN) res_d = b_below_a ? val_b_p1 : val_a_p1;
                else                 res_d = a_below_b ? val_b_p1 : val_a_p1;
                inv_d = any_snan;
            end
            OP_CLASS: begin
                res_d = {22'h0, cls_a_p1};
            end
            default: begin
                res_d = 32'h0;
                inv_d = 1'b1;
            end
        endcase
    end

    // ---- stage p2: output registers, loaded in EXEC and held until next capture
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= 32'h0;
            flags  <= 5'h0;
        end else if (state == EXEC) begin
            result <= res_d;
            flags  <= {inv_d, 4'b0000};
        end
    end

    // valid_out registered from the next state so it is glitch-free
    always_ff @(posedge clk) begin
        if (rst) valid_out <= 1'b0;
        else     valid_out <= (state_nxt == DONE);
    end

endmodule
